i2c_cmd_sequencer: RTL and testbench

- Walks a table of I2C commands and issues each one, in order, to the existing byte-oriented I2C master over its send/ready/done/status handshake.
- Used to bring up the HDMI path after reset: select the I2C mux channel, then load the transmitter register writes.
- Supports timed delay entries, per-command NACK retry with a back-off gap, and single-pulse completion or sticky error reporting.

---
 rtl/i2c_cmd_sequencer_if.sv | 20 ++
 rtl/i2c_cmd_sequencer.sv | 158 +++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_sequencer_if.sv
// Handshake bundle between the command sequencer and the byte-oriented
// I2C master: send/ready request side, done/status completion side.
interface i2c_cmd_sequencer_if;
  logic        i2c_send_o;
  logic [1:0]  i2c_nbytes_o;
  logic [23:0] i2c_data_o;
  logic        i2c_ready_i;
  logic        i2c_done_i;
  logic [2:0]  i2c_status_i;

  modport master (
    output i2c_send_o, i2c_nbytes_o, i2c_data_o,
    input  i2c_ready_i, i2c_done_i, i2c_status_i
  );

  modport slave (
    input  i2c_send_o, i2c_nbytes_o, i2c_data_o,
    output i2c_ready_i, i2c_done_i, i2c_status_i
  );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Walks a command table and issues each entry to the I2C master,
// with delay entries, NACK retry with back-off, and done/error reporting.
module i2c_cmd_sequencer #(
  parameter int NUM_CMDS  = 64,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 1000,
  parameter int IDX_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [IDX_W-1:0] err_index_o,
  output logic [IDX_W-1:0] cmd_addr_o,
  input  logic [25:0]      cmd_data_i,
  i2c_cmd_sequencer_if.master bus
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, FETCH, LATCH, ISSUE, WAIT_DONE, CHECK,
    DELAY, BACKOFF, NEXT, DONE, ERROR
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [IDX_W-1:0] addr_n, eidx_n;
  logic [RW-1:0]    retry, retry_n;
  logic [23:0]      cnt, cnt_n;
  logic [23:0]      data, data_n;
  logic [1:0]       nb, nb_n;
  logic [2:0]       st, st_n, mask;
  logic             busy_n, done_n, err_n;

  assign bus.i2c_send_o   = (state == ISSUE) && bus.i2c_ready_i;
  assign bus.i2c_nbytes_o = nb;
  assign bus.i2c_data_o   = data;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    addr_n  = cmd_addr_o;
    eidx_n  = err_index_o;
    retry_n = retry;
    cnt_n   = cnt;
    data_n  = data;
    nb_n    = nb;
    st_n    = st;
    busy_n  = busy_o;
    done_n  = 1'b0;
    err_n   = error_o;
    case (nb)
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    case (state)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          idx_n   = '0;
          addr_n  = '0;
          retry_n = '0;
          err_n   = 1'b0;
          busy_n  = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: state_n = LATCH;
      LATCH: begin
        if (cmd_data_i[25:24] == 2'd0) begin
          cnt_n   = cmd_data_i[23:0];
          state_n = DELAY;
        end else begin
          nb_n    = cmd_data_i[25:24];
          data_n  = cmd_data_i[23:0];
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.i2c_ready_i) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.i2c_done_i) begin
          st_n    = bus.i2c_status_i;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if ((st & mask) == mask) begin
          state_n = NEXT;
        end else if (retry < RW'(MAX_RETRY)) begin
          retry_n = retry + RW'(1);
          cnt_n   = 24'(RETRY_GAP);
          state_n = BACKOFF;
        end else begin
          eidx_n  = idx;
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = ERROR;
        end
      end
      // counter holds remaining cycles; a zero load still costs one cycle
      DELAY, BACKOFF: begin
        if (cnt <= 24'd1) begin
          cnt_n   = '0;
          state_n = (state == DELAY) ? NEXT : ISSUE;
        end else begin
          cnt_n = cnt - 24'd1;
        end
      end
      NEXT: begin
        retry_n = '0;
        if (idx == IDX_W'(NUM_CMDS - 1)) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = DONE;
        end else begin
          idx_n   = idx + IDX_W'(1);
          addr_n  = idx + IDX_W'(1);
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      cmd_addr_o  <= '0;
      err_index_o <= '0;
      retry       <= '0;
      cnt         <= '0;
      data        <= '0;
      nb          <= '0;
      st          <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cmd_addr_o  <= addr_n;
      err_index_o <= eidx_n;
      retry       <= retry_n;
      cnt         <= cnt_n;
      data        <= data_n;
      nb          <= nb_n;
      st          <= st_n;
      busy_o      <= busy_n;
      done_o      <= done_n;
      error_o     <= err_n;
    end
  end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench: expected sends queued at start, popped on each accepted
// send; a small I2C master model answers with scripted ACK status.
module tb_i2c_cmd_sequencer;
  localparam int NC  = 3;
  localparam int MR  = 3;
  localparam int GAP = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        busy, done, error;
  logic [7:0]  err_index, cmd_addr;
  logic [25:0] cmd_data;
  logic [25:0] tbl [0:3];

  i2c_cmd_sequencer_if bus();

  i2c_cmd_sequencer #(
    .NUM_CMDS(NC), .MAX_RETRY(MR), .RETRY_GAP(GAP), .IDX_W(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .busy_o(busy), .done_o(done), .error_o(error),
    .err_index_o(err_index), .cmd_addr_o(cmd_addr),
    .cmd_data_i(cmd_data), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) cmd_data <= tbl[cmd_addr[1:0]];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // I2C master model: 4-cycle frame, status scripted by st_q (default ACK all)
  int         m_cnt = 0;
  logic       m_done = 1'b0;
  logic [2:0] m_status = 3'b000;
  logic [2:0] st_q [$];

  assign bus.i2c_ready_i  = (m_cnt == 0) && !hold;
  assign bus.i2c_done_i   = m_done;
  assign bus.i2c_status_i = m_status;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done   <= 1'b1;
        m_status <= (st_q.size() != 0) ? st_q.pop_front() : 3'b111;
      end
    end else if (bus.i2c_send_o && bus.i2c_ready_i) begin
      m_cnt <= 4;
    end
  end

  typedef struct packed {
    logic [1:0]  nb;
    logic [23:0] d;
  } exp_t;

  exp_t sb [$];
  exp_t e_m;
  int   sc [$];
  int   dc [$];
  int   done_cnt = 0;
  int   bad_send = 0;
  int   extra = 0;

  always @(negedge clk) begin
    if (bus.i2c_send_o && !bus.i2c_ready_i) bad_send++;
    if (bus.i2c_send_o && bus.i2c_ready_i) begin
      sc.push_back(cyc);
      if (sb.size() == 0) extra++;
      else begin
        e_m = sb.pop_front();
        check("send_nbytes", bus.i2c_nbytes_o, e_m.nb);
        check("send_data", bus.i2c_data_o, e_m.d);
      end
    end
    if (bus.i2c_done_i) dc.push_back(cyc);
    if (done) begin
      done_cnt++;
      check("busy_at_done", busy, 0);
    end
  end

  task automatic begin_run();
    sc.delete();
    dc.delete();
    done_cnt = 0;
    bad_send = 0;
    extra = 0;
  endtask

  task automatic push(input logic [1:0] nb, input logic [23:0] d);
    sb.push_back(exp_t'({nb, d}));
  endtask

  task automatic go();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done || error) break;
      @(negedge clk);
    end
    check("finish_in_budget", (done || error), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic end_run();
    check("sb_drained", sb.size(), 0);
    check("extra_sends", extra, 0);
    check("send_without_ready", bad_send, 0);
    check("busy_end", busy, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_err_index"}, err_index, 0);
    check({tag, "_cmd_addr"}, cmd_addr, 0);
    check({tag, "_send"}, bus.i2c_send_o, 0);
    check({tag, "_nbytes"}, bus.i2c_nbytes_o, 0);
    check({tag, "_data"}, bus.i2c_data_o, 0);
  endtask

  task automatic push_basic();
    push(2'd1, 24'h000074);
    push(2'd3, 24'h104172);
    push(2'd3, 24'h009872);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{26'h1000074, 26'h3104172, 26'h3009872, 26'h0000000};
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // basic three-entry run, all ACK
    begin_run();
    push_basic();
    go();
    check("busy_after_start", busy, 1);
    wait_end(500);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_error", error, 0);
    check("basic_n_send", sc.size(), 3);
    check("basic_gap01", sc[1] - dc[0], 5);
    check("basic_gap12", sc[2] - dc[1], 5);
    end_run();

    // 100-cycle delay entry between two writes
    tbl = '{26'h3104172, 26'h0000064, 26'h3009872, 26'h0000000};
    begin_run();
    push(2'd3, 24'h104172);
    push(2'd3, 24'h009872);
    go();
    wait_end(2000);
    check("delay_done_cnt", done_cnt, 1);
    check("delay_n_send", sc.size(), 2);
    check("delay_gap", sc[1] - dc[0], 108);
    end_run();

    // two NACKs then ACK on entry 1
    tbl = '{26'h1000074, 26'h3104172, 26'h3009872, 26'h0000000};
    begin_run();
    st_q = '{3'b111, 3'b011, 3'b011, 3'b111, 3'b111};
    push(2'd1, 24'h000074);
    repeat (3) push(2'd3, 24'h104172);
    push(2'd3, 24'h009872);
    go();
    wait_end(10000);
    check("retry_done_cnt", done_cnt, 1);
    check("retry_error", error, 0);
    check("retry_n_send", sc.size(), 5);
    check("retry_gap0", sc[1] - dc[0], 5);
    check("retry_gap1", sc[2] - dc[1], GAP + 2);
    check("retry_gap2", sc[3] - dc[2], GAP + 2);
    check("retry_gap3", sc[4] - dc[3], 5);
    end_run();

    // entry 2 never fully ACKed: retries exhausted
    begin_run();
    st_q = '{3'b111, 3'b111, 3'b001, 3'b001, 3'b001, 3'b001};
    push(2'd1, 24'h000074);
    push(2'd3, 24'h104172);
    repeat (4) push(2'd3, 24'h009872);
    go();
    wait_end(10000);
    check("err_error", error, 1);
    check("err_index", err_index, 2);
    check("err_done_cnt", done_cnt, 0);
    check("err_n_send", sc.size(), 6);
    end_run();
    repeat (5) @(negedge clk);
    check("err_sticky", error, 1);

    // restart after error
    st_q.delete();
    begin_run();
    push_basic();
    go();
    check("restart_error_clr", error, 0);
    check("restart_busy", busy, 1);
    wait_end(500);
    check("restart_done_cnt", done_cnt, 1);
    check("restart_n_send", sc.size(), 3);
    end_run();

    // master not ready for 50 cycles
    hold = 1'b1;
    begin_run();
    push_basic();
    go();
    repeat (50) @(negedge clk);
    check("hold_no_send", sc.size(), 0);
    check("hold_busy", busy, 1);
    hold = 1'b0;
    wait_end(500);
    check("hold_done_cnt", done_cnt, 1);
    check("hold_n_send", sc.size(), 3);
    end_run();

    // reset while waiting for the first frame to finish
    begin_run();
    push_basic();
    go();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sc.size() != 0) break;
    end
    check("rst_first_send", sc.size(), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    rst = 1'b0;
    sb.delete();
    repeat (8) @(negedge clk);
    check("late_done_seen", dc.size(), 1);
    check("late_done_busy", busy, 0);
    check("late_done_no_send", sc.size(), 1);
    check("late_done_no_done", done_cnt, 0);
    begin_run();
    push_basic();
    go();
    wait_end(500);
    check("post_rst_done_cnt", done_cnt, 1);
    check("post_rst_n_send", sc.size(), 3);
    end_run();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
